alu_unit: RTL and testbench
===========================

# alu_unit

Single-cycle registered integer execution unit. Sits directly downstream of the reservation station: it consumes one ready RV32I non-memory instruction per cycle (`FU_*` bundle) and, one clock later, drives the ALU result bus (`exc_*`). The RS, LSB and ROB snoop that bus for operand wakeup and commit, and the ROB uses its branch fields for misprediction handling.

## Interface
- No module parameters. Widths come from `config.v`: `OP_LOG` is the opcode-index width, `ROB_LOG` is the ROB tag width. Op codes are the `config.v` `OP_*` macros.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (polarity/synchronicity fixed).
- `rdy`  in  1  global ready; low = freeze all state.
- `jump_flag`  in  1  ROB flush; synchronous, drops in-flight result.
- `FU_enable`  in  1  instruction valid this cycle.
- `FU_op`  in  `OP_LOG`  operation code.
- `FU_Vj`, `FU_Vk`  in  32  resolved rs1 / rs2 values.
- `FU_Imm`  in  32  sign-/zero-extended immediate as produced by decode.
- `FU_DestRob`  in  `ROB_LOG`  destination ROB tag.
- `FU_CurPC`  in  32  PC of the instruction.
- `exc_valid`  out  1  result valid (one cycle per accepted instruction).
- `exc_RobId`  out  `ROB_LOG`  tag of the result.
- `exc_value`  out  32  rd write value.
- `exc_jump`  out  1  control transfer taken (branch taken, JAL, JALR).
- `exc_target`  out  32  resolved next PC: target if `exc_jump`, else PC+4.

## Operation
- Supported ops: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI, ADD/SUB/SLL/SLT/SLTU/XOR/OR/AND/SRL/SRA.
- Operand B is `FU_Imm` for I-type ops and `FU_Vk` for R-type ops and branches.
- Shift amount = operand B[4:0]. SRA/SRAI are arithmetic; SLL/SRL are logical.
- SLT/SLTI compare signed; SLTU/SLTIU/BLTU/BGEU compare unsigned. The result is 32'd0 or 32'd1.
- LUI: value = Imm. AUIPC: value = PC+Imm. Both set `exc_jump`=0 and target = PC+4.
- JAL: value = PC+4, jump=1, target = PC+Imm.
- JALR: value = PC+4, jump=1, target = (Vj+Imm) & 32'hFFFFFFFE.
- Branches: value = 0, jump = condition, target = cond ? PC+Imm : PC+4.
- All arithmetic is mod 2^32; there is no overflow flag.
- Undefined op code: the result is still emitted with `exc_valid`=1, value=0, jump=0, target=PC+4.
- State is the output register set only; no internal queue. Throughput is 1 instruction/cycle with no backpressure (RS issues only when ready).

## Timing
- Reset (`rst`=0, asynchronous): `exc_valid`=0, `exc_RobId`=0, `exc_value`=0, `exc_jump`=0, `exc_target`=0, all immediately and held until `rst` rises.
- The priority at each rising edge with `rst`=1 is as follows:
  - `jump_flag` takes precedence over everything: `exc_valid`<=0 and `exc_jump`<=0; any `FU_enable` that cycle is discarded. Data fields may hold.
  - Otherwise, if `rdy`=0: every output register holds its value, including `exc_valid`. A pending result therefore persists until `rdy` returns.
  - Otherwise, if `FU_enable`=1: all outputs load the computed result, `exc_valid`<=1.
  - Otherwise, `exc_valid`<=0 and `exc_jump`<=0; data fields hold.
- Latency: instruction sampled at edge N, so the result is visible after edge N and consumed at edge N+1.
- Back-to-back enables produce back-to-back valid results with no bubble.
- `exc_jump` is never 1 while `exc_valid` is 0.

## Test plan
- Reset, then idle: hold `rst`=0 mid-cycle. All outputs go to 0 asynchronously. Release with `FU_enable`=0: `exc_valid` stays 0.
- ALU ops:
  - ADD with Vj=32'h7FFFFFFF, Vk=1 gives value 32'h80000000 one cycle later, with tag echoed.
  - SUB with 0−1 gives 32'hFFFFFFFF.
  - SRAI with Vj=32'h80000000, Imm=4 gives 32'hF8000000.
  - SLTU with Vj=1, Vk=32'hFFFFFFFF gives 1; SLT with the same operands gives 0.
- Control:
  - BEQ with PC=32'h100, Imm=32'h20, Vj=Vk=5 gives jump=1, target=32'h120. With Vk=6: jump=0, target=32'h104.
  - JALR with Vj=32'h203, Imm=0, PC=32'h40 gives value=32'h44, target=32'h202.
- Back-to-back: issue 4 ADDs on consecutive cycles with tags 1,2,3,4. Expect 4 consecutive `exc_valid` cycles with tags 1,2,3,4 and correct values.
- Stall: accept ADD (tag 3), then drop `rdy` for 3 cycles. `exc_valid`=1 and tag 3 are held throughout; one cycle after `rdy` rises with `FU_enable`=0, `exc_valid`=0.
- Flush: `FU_enable`=1 together with `jump_flag`=1. Next cycle `exc_valid`=0 and `exc_jump`=0. Also assert `jump_flag` with `rdy`=0 while a result is pending: the result is cleared.

Source files
------------

// File: rtl/alu_unit.sv
// alu_unit: single-cycle registered RV32I integer/branch execution unit driving the ALU result bus.
`ifndef OP_LOG
`define OP_LOG 6
`define ROB_LOG 4
`define OP_LUI   6'd1
`define OP_AUIPC 6'd2
`define OP_JAL   6'd3
`define OP_JALR  6'd4
`define OP_BEQ   6'd5
`define OP_BNE   6'd6
`define OP_BLT   6'd7
`define OP_BGE   6'd8
`define OP_BLTU  6'd9
`define OP_BGEU  6'd10
`define OP_ADDI  6'd11
`define OP_SLTI  6'd12
`define OP_SLTIU 6'd13
`define OP_XORI  6'd14
`define OP_ORI   6'd15
`define OP_ANDI  6'd16
`define OP_SLLI  6'd17
`define OP_SRLI  6'd18
`define OP_SRAI  6'd19
`define OP_ADD   6'd20
`define OP_SUB   6'd21
`define OP_SLL   6'd22
`define OP_SLT   6'd23
`define OP_SLTU  6'd24
`define OP_XOR   6'd25
`define OP_OR    6'd26
`define OP_AND   6'd27
`define OP_SRL   6'd28
`define OP_SRA   6'd29
`endif

module alu_unit (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                jump_flag,
  input  logic                FU_enable,
  input  logic [`OP_LOG-1:0]  FU_op,
  input  logic [31:0]         FU_Vj,
  input  logic [31:0]         FU_Vk,
  input  logic [31:0]         FU_Imm,
  input  logic [`ROB_LOG-1:0] FU_DestRob,
  input  logic [31:0]         FU_CurPC,
  output logic                exc_valid,
  output logic [`ROB_LOG-1:0] exc_RobId,
  output logic [31:0]         exc_value,
  output logic                exc_jump,
  output logic [31:0]         exc_target
);
  logic [31:0] b, pc4, br_tgt, value, target;
  logic [4:0] sh;
  logic is_imm, is_br, eq, lt, ltu, jump;
  assign is_imm = FU_op >= `OP_ADDI && FU_op <= `OP_SRAI;
  assign is_br = FU_op >= `OP_BEQ && FU_op <= `OP_BGEU;
  assign b = is_imm ? FU_Imm : FU_Vk;
  assign sh = b[4:0];
  assign pc4 = FU_CurPC + 32'd4;
  assign br_tgt = FU_CurPC + FU_Imm;
  assign eq = FU_Vj == b;
  assign lt = $signed(FU_Vj) < $signed(b);
  assign ltu = FU_Vj < b;
  always_comb begin
    value = '0;
    jump = 1'b0;
    case (FU_op)
      `OP_LUI: value = FU_Imm;
      `OP_AUIPC: value = br_tgt;
      `OP_JAL, `OP_JALR: begin value = pc4; jump = 1'b1; end
      `OP_BEQ: jump = eq;
      `OP_BNE: jump = !eq;
      `OP_BLT: jump = lt;
      `OP_BGE: jump = !lt;
      `OP_BLTU: jump = ltu;
      `OP_BGEU: jump = !ltu;
      `OP_ADDI, `OP_ADD: value = FU_Vj + b;
      `OP_SUB: value = FU_Vj - b;
      `OP_SLTI, `OP_SLT: value = {31'd0, lt};
      `OP_SLTIU, `OP_SLTU: value = {31'd0, ltu};
      `OP_XORI, `OP_XOR: value = FU_Vj ^ b;
      `OP_ORI, `OP_OR: value = FU_Vj | b;
      `OP_ANDI, `OP_AND: value = FU_Vj & b;
      `OP_SLLI, `OP_SLL: value = FU_Vj << sh;
      `OP_SRLI, `OP_SRL: value = FU_Vj >> sh;
      `OP_SRAI, `OP_SRA: value = $signed(FU_Vj) >>> sh;
      default: value = '0;
    endcase
  end
  // JALR drops bit 0 of its computed target; taken branches and JAL share PC+Imm
  assign target = FU_op == `OP_JALR ? (FU_Vj + FU_Imm) & ~32'd1 :
                  (FU_op == `OP_JAL || (is_br && jump)) ? br_tgt : pc4;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_valid <= 1'b0;
      exc_RobId <= '0;
      exc_value <= '0;
      exc_jump <= 1'b0;
      exc_target <= '0;
    end else if (jump_flag) begin
      exc_valid <= 1'b0;
      exc_jump <= 1'b0;
    end else if (rdy) begin
      exc_valid <= FU_enable;
      exc_jump <= FU_enable && jump;
      if (FU_enable) begin
        exc_RobId <= FU_DestRob;
        exc_value <= value;
        exc_target <= target;
      end
    end
  end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: scoreboard bench for alu_unit with directed cases and a random reference-model phase.
`ifndef OP_LOG
`define OP_LOG 6
`define ROB_LOG 4
`define OP_LUI   6'd1
`define OP_AUIPC 6'd2
`define OP_JAL   6'd3
`define OP_JALR  6'd4
`define OP_BEQ   6'd5
`define OP_BNE   6'd6
`define OP_BLT   6'd7
`define OP_BGE   6'd8
`define OP_BLTU  6'd9
`define OP_BGEU  6'd10
`define OP_ADDI  6'd11
`define OP_SLTI  6'd12
`define OP_SLTIU 6'd13
`define OP_XORI  6'd14
`define OP_ORI   6'd15
`define OP_ANDI  6'd16
`define OP_SLLI  6'd17
`define OP_SRLI  6'd18
`define OP_SRAI  6'd19
`define OP_ADD   6'd20
`define OP_SUB   6'd21
`define OP_SLL   6'd22
`define OP_SLT   6'd23
`define OP_SLTU  6'd24
`define OP_XOR   6'd25
`define OP_OR    6'd26
`define OP_AND   6'd27
`define OP_SRL   6'd28
`define OP_SRA   6'd29
`endif

module tb_alu_unit;
  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] value;
    logic        jump;
    logic [31:0] target;
  } exp_t;

  logic clk = 0, rst = 0, rdy = 1, jump_flag = 0, FU_enable = 0;
  logic [5:0] FU_op = 0;
  logic [31:0] FU_Vj = 0, FU_Vk = 0, FU_Imm = 0, FU_CurPC = 0;
  logic [3:0] FU_DestRob = 0;
  logic exc_valid, exc_jump;
  logic [3:0] exc_RobId;
  logic [31:0] exc_value, exc_target;
  int checks = 0, fails = 0;
  exp_t q[$];

  alu_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_flag(jump_flag), .FU_enable(FU_enable),
    .FU_op(FU_op), .FU_Vj(FU_Vj), .FU_Vk(FU_Vk), .FU_Imm(FU_Imm),
    .FU_DestRob(FU_DestRob), .FU_CurPC(FU_CurPC),
    .exc_valid(exc_valid), .exc_RobId(exc_RobId), .exc_value(exc_value),
    .exc_jump(exc_jump), .exc_target(exc_target)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(logic [3:0] tag, logic [31:0] v, logic j, logic [31:0] t);
    exp_t e;
    e.tag = tag; e.value = v; e.jump = j; e.target = t;
    return e;
  endfunction

  function automatic exp_t model(logic [5:0] op, logic [31:0] vj, logic [31:0] vk,
                                 logic [31:0] imm, logic [31:0] pc, logic [3:0] tag);
    logic [31:0] b, v, t;
    logic j;
    int sh;
    longint sa, sb;
    b = (op >= `OP_ADDI && op <= `OP_SRAI) ? imm : vk;
    sh = int'(b[4:0]);
    sa = longint'($signed(vj));
    sb = longint'($signed(b));
    v = 0;
    j = 0;
    t = pc + 4;
    case (op)
      `OP_LUI: v = imm;
      `OP_AUIPC: v = pc + imm;
      `OP_JAL: begin v = pc + 4; j = 1; t = pc + imm; end
      `OP_JALR: begin v = pc + 4; j = 1; t = (vj + imm) & 32'hFFFF_FFFE; end
      `OP_BEQ: j = vj == vk;
      `OP_BNE: j = vj != vk;
      `OP_BLT: j = sa < sb;
      `OP_BGE: j = sa >= sb;
      `OP_BLTU: j = {32'd0, vj} < {32'd0, vk};
      `OP_BGEU: j = {32'd0, vj} >= {32'd0, vk};
      `OP_ADDI, `OP_ADD: v = 32'(sa + sb);
      `OP_SUB: v = 32'(sa - sb);
      `OP_SLTI, `OP_SLT: v = sa < sb ? 1 : 0;
      `OP_SLTIU, `OP_SLTU: v = {32'd0, vj} < {32'd0, b} ? 1 : 0;
      `OP_XORI, `OP_XOR: v = vj ^ b;
      `OP_ORI, `OP_OR: v = vj | b;
      `OP_ANDI, `OP_AND: v = vj & b;
      `OP_SLLI, `OP_SLL: v = 32'({32'd0, vj} * (64'd1 << sh));
      `OP_SRLI, `OP_SRL: v = 32'({32'd0, vj} / (64'd1 << sh));
      `OP_SRAI, `OP_SRA: v = 32'(sa >>> sh);
      default: v = 0;
    endcase
    if (op >= `OP_BEQ && op <= `OP_BGEU && j) t = pc + imm;
    return mk(tag, v, j, t);
  endfunction

  task automatic step(bit en, logic [5:0] op, logic [31:0] vj, logic [31:0] vk,
                      logic [31:0] imm, logic [31:0] pc, logic [3:0] tag, exp_t e,
                      bit r, bit jf);
    FU_enable = en; FU_op = op; FU_Vj = vj; FU_Vk = vk; FU_Imm = imm;
    FU_CurPC = pc; FU_DestRob = tag; rdy = r; jump_flag = jf;
    if (en && r && !jf) q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(bit r);
    step(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0), r, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("jump_without_valid", exc_jump && !exc_valid, 0);
      if (exc_valid) begin
        if (q.size() == 0) chk("unexpected_result", {exc_RobId, exc_value, exc_jump, exc_target}, 0);
        else chk("result", {exc_RobId, exc_value, exc_jump, exc_target}, q[0]);
      end
    end
  end

  always @(posedge clk)
    if (rst && exc_valid && (rdy || jump_flag) && q.size() > 0) void'(q.pop_front());

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] op;
    logic [31:0] vj, vk, imm, pc;
    logic [3:0] tag;
    bit en, r, jf;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", exc_valid, 0);
    chk("reset_outputs", {exc_RobId, exc_value, exc_jump, exc_target}, 0);
    rst = 1;
    idle(1);
    idle(1);
    chk("idle_valid", exc_valid, 0);
    // async reset mid-cycle with a taken JAL pending
    step(1, `OP_JAL, 0, 0, 32'h10, 32'h80, 4'd7, mk(7, 32'h84, 1, 32'h90), 1, 0);
    FU_enable = 0;
    @(negedge clk);
    #2 rst = 0;
    #1;
    chk("async_valid", exc_valid, 0);
    chk("async_tag", exc_RobId, 0);
    chk("async_value", exc_value, 0);
    chk("async_jump", exc_jump, 0);
    chk("async_target", exc_target, 0);
    q.delete();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    step(1, `OP_ADD, 32'h7FFF_FFFF, 1, 0, 32'h0, 4'd1, mk(1, 32'h8000_0000, 0, 32'h4), 1, 0);
    step(1, `OP_SUB, 0, 1, 0, 32'h8, 4'd2, mk(2, 32'hFFFF_FFFF, 0, 32'hC), 1, 0);
    step(1, `OP_SRAI, 32'h8000_0000, 0, 4, 32'h10, 4'd3, mk(3, 32'hF800_0000, 0, 32'h14), 1, 0);
    step(1, `OP_SLTU, 1, 32'hFFFF_FFFF, 0, 32'h14, 4'd4, mk(4, 1, 0, 32'h18), 1, 0);
    step(1, `OP_SLT, 1, 32'hFFFF_FFFF, 0, 32'h18, 4'd5, mk(5, 0, 0, 32'h1C), 1, 0);
    step(1, `OP_BEQ, 5, 5, 32'h20, 32'h100, 4'd6, mk(6, 0, 1, 32'h120), 1, 0);
    step(1, `OP_BEQ, 5, 6, 32'h20, 32'h100, 4'd7, mk(7, 0, 0, 32'h104), 1, 0);
    step(1, `OP_JALR, 32'h203, 0, 0, 32'h40, 4'd8, mk(8, 32'h44, 1, 32'h202), 1, 0);
    step(1, `OP_LUI, 0, 0, 32'hABCD_E000, 32'h50, 4'd9, mk(9, 32'hABCD_E000, 0, 32'h54), 1, 0);
    step(1, 6'd63, 3, 4, 5, 32'h60, 4'd10, mk(10, 0, 0, 32'h64), 1, 0);
    idle(1);
    for (int i = 1; i <= 4; i++) begin
      step(1, `OP_ADD, 32'(i * 100), 32'(i), 0, 32'h200, 4'(i), mk(4'(i), 32'(i * 101), 0, 32'h204), 1, 0);
      chk("b2b_valid", exc_valid, 1);
      chk("b2b_tag", exc_RobId, i);
    end
    idle(1);
    step(1, `OP_ADD, 2, 3, 0, 32'h300, 4'd3, mk(3, 5, 0, 32'h304), 1, 0);
    for (int i = 0; i < 3; i++) begin
      idle(0);
      chk("stall_valid", exc_valid, 1);
      chk("stall_tag", exc_RobId, 3);
    end
    idle(1);
    chk("stall_release_valid", exc_valid, 0);
    step(1, `OP_JAL, 0, 0, 32'h40, 32'h400, 4'd1, mk(1, 32'h404, 1, 32'h440), 1, 0);
    step(1, `OP_ADD, 1, 1, 0, 32'h404, 4'd2, mk(2, 2, 0, 32'h408), 1, 1);
    chk("flush_valid", exc_valid, 0);
    chk("flush_jump", exc_jump, 0);
    step(1, `OP_BNE, 1, 2, 32'h8, 32'h500, 4'd5, mk(5, 0, 1, 32'h508), 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0), 0, 1);
    chk("flush_stalled_valid", exc_valid, 0);
    chk("flush_stalled_jump", exc_jump, 0);
    for (int i = 0; i < 600; i++) begin
      op = 6'($urandom_range(0, 31));
      vj = $urandom;
      vk = $urandom_range(0, 3) == 0 ? vj : $urandom;
      imm = $urandom_range(0, 1) ? 32'($signed($urandom_range(0, 4095)) - 2048) : $urandom;
      pc = $urandom & 32'hFFFF_FFFC;
      tag = 4'($urandom);
      en = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 4) != 0;
      jf = $urandom_range(0, 19) == 0;
      step(en, op, vj, vk, imm, pc, tag, model(op, vj, vk, imm, pc, tag), r, jf);
    end
    idle(1);
    idle(1);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
